// File: rtl/ccg_sweep_pkg.sv
// Shared types and default MISR constants for the combinational-netlist sweep sequencer.
package ccg_sweep_pkg;
  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, RESULT} state_e;

  localparam logic [31:0] MISR_POLY_DEF = 32'h04C11DB7;
  localparam logic [31:0] MISR_SEED_DEF = 32'hFFFFFFFF;
endpackage

// File: rtl/ccg_misr.sv
// Multiple-input signature register: shift-left LFSR with polynomial feedback, XORed with din.
module ccg_misr #(
  parameter int           W    = 32,
  parameter logic [W-1:0] POLY = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] seed,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] sig
);
  logic [W-1:0] sig_q, sig_d;

  always_comb begin
    sig_d = sig_q;
    if (load)    sig_d = seed;
    else if (en) sig_d = {sig_q[W-2:0], 1'b0} ^ (sig_q[W-1] ? POLY : '0) ^ din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sig_q <= '0;
    else     sig_q <= sig_d;
  end

  assign sig = sig_q;
endmodule

// File: rtl/ccg_sweep_ctrl.sv
// Sweeps an input-vector range through a combinational netlist and returns a MISR fingerprint.
// Optional macro CCG_SWEEP_ONES_EN adds res_ones: count of vectors with any output bit set.
module ccg_sweep_ctrl
  import ccg_sweep_pkg::*;
#(
  parameter int                IN_W      = 10,
  parameter int                OUT_W     = 30,
  parameter int                MISR_W    = 32,
  parameter int                SETTLE    = 2,
  parameter logic [MISR_W-1:0] MISR_POLY = MISR_W'(MISR_POLY_DEF),
  parameter logic [MISR_W-1:0] MISR_SEED = MISR_W'(MISR_SEED_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [IN_W-1:0]   cmd_first,
  input  logic [IN_W-1:0]   cmd_last,
  input  logic              abort,
  output logic [IN_W-1:0]   dut_in,
  input  logic [OUT_W-1:0]  dut_out,
  output logic              busy,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [MISR_W-1:0] res_sig,
`ifdef CCG_SWEEP_ONES_EN
  output logic [IN_W:0]     res_ones,
`endif
  output logic [IN_W:0]     res_count
);
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  if (OUT_W > MISR_W || SETTLE < 1) begin : g_param_err
    $error("ccg_sweep_ctrl: need OUT_W <= MISR_W and SETTLE >= 1");
  end

  state_e            state_q;
  logic [IN_W-1:0]   vec_q, last_q;
  logic [IN_W:0]     cnt_q, res_count_q;
  logic [SW-1:0]     settle_q;
  logic              res_valid_q;
  logic [MISR_W-1:0] res_sig_q, misr_sig;
  logic              accept;
`ifdef CCG_SWEEP_ONES_EN
  logic [IN_W:0]     ones_q, res_ones_q;
`endif

  assign cmd_ready = (state_q == IDLE) & ~abort;
  assign accept    = cmd_valid & cmd_ready;

  ccg_misr #(.W(MISR_W), .POLY(MISR_POLY)) u_misr (
    .clk (clk),
    .rst (rst),
    .load(accept),
    .seed(MISR_SEED),
    .en  (state_q == SAMPLE),
    .din (MISR_W'(dut_out)),
    .sig (misr_sig)
  );

  // The first RESULT cycle copies the signature into the output registers,
  // so res_* stay valid while the MISR is free to be reseeded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      vec_q       <= '0;
      last_q      <= '0;
      cnt_q       <= '0;
      settle_q    <= '0;
      res_valid_q <= 1'b0;
      res_sig_q   <= '0;
      res_count_q <= '0;
`ifdef CCG_SWEEP_ONES_EN
      ones_q      <= '0;
      res_ones_q  <= '0;
`endif
    end else if (state_q == IDLE) begin
      if (accept) begin
        state_q  <= DRIVE;
        vec_q    <= cmd_first;
        last_q   <= cmd_last;
        cnt_q    <= '0;
        settle_q <= SW'(SETTLE - 1);
`ifdef CCG_SWEEP_ONES_EN
        ones_q   <= '0;
`endif
      end
    end else if (abort) begin
      state_q     <= IDLE;
      res_valid_q <= 1'b0;
    end else begin
      case (state_q)
        DRIVE: begin
          if (settle_q == '0) state_q <= SAMPLE;
          else                settle_q <= settle_q - SW'(1);
        end
        SAMPLE: begin
          cnt_q <= cnt_q + (IN_W+1)'(1);
`ifdef CCG_SWEEP_ONES_EN
          ones_q <= ones_q + {{IN_W{1'b0}}, |dut_out};
`endif
          if (vec_q == last_q) begin
            state_q <= RESULT;
          end else begin
            vec_q    <= vec_q + IN_W'(1);
            settle_q <= SW'(SETTLE - 1);
            state_q  <= DRIVE;
          end
        end
        RESULT: begin
          if (!res_valid_q) begin
            res_valid_q <= 1'b1;
            res_sig_q   <= misr_sig;
            res_count_q <= cnt_q;
`ifdef CCG_SWEEP_ONES_EN
            res_ones_q  <= ones_q;
`endif
          end else if (res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dut_in    = vec_q;
  assign busy      = (state_q != IDLE);
  assign res_valid = res_valid_q;
  assign res_sig   = res_sig_q;
  assign res_count = res_count_q;
`ifdef CCG_SWEEP_ONES_EN
  assign res_ones  = res_ones_q;
`endif
endmodule

// File: tb/tb_ccg_sweep_ctrl.sv
// Directed bench for ccg_sweep_ctrl with a golden netlist model and reference MISR.
module tb_ccg_sweep_ctrl;
  localparam int IN_W = 10, OUT_W = 30, MISR_W = 32, SETTLE = 2;
  localparam logic [31:0] POLY = 32'h04C11DB7, SEED = 32'hFFFFFFFF;

  logic              clk, rst, cmd_valid, cmd_ready, abort, busy, res_valid, res_ready;
  logic [IN_W-1:0]   cmd_first, cmd_last, dut_in;
  logic [OUT_W-1:0]  dut_out, const_out;
  logic [MISR_W-1:0] res_sig;
  logic [IN_W:0]     res_count;
`ifdef CCG_SWEEP_ONES_EN
  logic [IN_W:0]     res_ones;
`endif
  bit                use_model;
  int                checks, fails;
  logic [IN_W-1:0]   seen[$];

  function automatic logic [OUT_W-1:0] netlist(input logic [IN_W-1:0] x);
    if (x[1:0] == 2'b00) return '0;
    return {x ^ {x[4:0], x[9:5]}, x + 10'd37, ~x};
  endfunction

  function automatic logic [31:0] misr_step(input logic [31:0] s, input logic [OUT_W-1:0] d);
    return {s[30:0], 1'b0} ^ (s[31] ? POLY : 32'h0) ^ {2'b00, d};
  endfunction

  assign dut_out = use_model ? netlist(dut_in) : const_out;

  ccg_sweep_ctrl #(.IN_W(IN_W), .OUT_W(OUT_W), .MISR_W(MISR_W), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_first(cmd_first), .cmd_last(cmd_last), .abort(abort), .dut_in(dut_in),
    .dut_out(dut_out), .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
    .res_sig(res_sig),
`ifdef CCG_SWEEP_ONES_EN
    .res_ones(res_ones),
`endif
    .res_count(res_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one command, then track dut_in until res_valid (bounded); every
  // vector must be held SETTLE+1 cycles.
  task automatic run_sweep(input logic [IN_W-1:0] first, input logic [IN_W-1:0] last,
                           input int bound, output int cycles, output bit runs_ok);
    int run;
    cmd_first = first; cmd_last = last; cmd_valid = 1'b1;
    @(posedge clk); #1; cmd_valid = 1'b0;
    seen.delete(); seen.push_back(dut_in); run = 1; runs_ok = 1'b1; cycles = 0;
    while (res_valid !== 1'b1 && cycles < bound) begin
      @(posedge clk); #1; cycles++;
      if (dut_in !== seen[$]) begin
        if (run != SETTLE + 1) runs_ok = 1'b0;
        seen.push_back(dut_in); run = 1;
      end else run++;
    end
  endtask

  task automatic drain(output bit ok);
    int n = 0;
    while (res_valid !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    ok = (res_valid === 1'b1);
    res_ready = 1'b1; @(posedge clk); #1; res_ready = 1'b0;
    ok &= (res_valid === 1'b0) && (cmd_ready === 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 0; abort = 0; res_ready = 0; cmd_first = 0; cmd_last = 0;
    use_model = 0; const_out = '0;
    repeat (2) @(posedge clk); #1;
    checks++;
    if (dut_in !== 0 || busy !== 0 || res_valid !== 0 || res_sig !== 0 || res_count !== 0) begin
      fails++; $display("FAIL reset_vals: dut_in=%0d busy=%b rv=%b sig=%h cnt=%0d, expected all 0",
                        dut_in, busy, res_valid, res_sig, res_count);
    end
    rst = 1'b0; #1;
    checks++;
    if (cmd_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b expected 1", cmd_ready); end
  endtask

  task automatic test_single();
    int cyc; bit ok;
    use_model = 0; const_out = '0;
    run_sweep(10'd3, 10'd3, 20, cyc, ok);
    checks++;
    if (cyc != 4) begin fails++; $display("FAIL single_latency: got %0d expected 4", cyc); end
    checks++;
    if (seen.size() != 1 || seen[0] !== 10'd3) begin
      fails++; $display("FAIL single_vec: got %0d vectors first=%0d expected 1 vector 3", seen.size(), seen[0]);
    end
    checks++;
    if (res_sig !== 32'hFB3EE249) begin fails++; $display("FAIL single_sig: got %h expected fb3ee249", res_sig); end
    checks++;
    if (res_count !== 11'd1) begin fails++; $display("FAIL single_count: got %0d expected 1", res_count); end
`ifdef CCG_SWEEP_ONES_EN
    checks++;
    if (res_ones !== 11'd0) begin fails++; $display("FAIL single_ones: got %0d expected 0", res_ones); end
`endif
    drain(ok);
    checks++;
    if (!ok) begin fails++; $display("FAIL single_drain: handshake ok=%b expected 1", ok); end
  endtask

  task automatic test_full_sweep();
    int cyc, ones; bit ok, order_ok; logic [31:0] exp_sig;
    use_model = 1; exp_sig = SEED; ones = 0;
    for (int v = 0; v < 1024; v++) begin
      exp_sig = misr_step(exp_sig, netlist(v[9:0]));
      if (netlist(v[9:0]) != 0) ones++;
    end
    run_sweep(10'd0, 10'd1023, 4000, cyc, ok);
    checks++;
    if (cyc != 3073) begin fails++; $display("FAIL full_cycles: got %0d expected 3073", cyc); end
    order_ok = (seen.size() == 1024);
    for (int i = 0; i < seen.size(); i++) if (seen[i] !== i[9:0]) order_ok = 0;
    checks++;
    if (!order_ok || !ok) begin
      fails++; $display("FAIL full_order: %0d vectors order_ok=%b hold_ok=%b expected 1024/1/1", seen.size(), order_ok, ok);
    end
    checks++;
    if (res_count !== 11'd1024) begin fails++; $display("FAIL full_count: got %0d expected 1024", res_count); end
    checks++;
    if (res_sig !== exp_sig) begin fails++; $display("FAIL full_sig: got %h expected %h", res_sig, exp_sig); end
`ifdef CCG_SWEEP_ONES_EN
    checks++;
    if (res_ones !== ones[10:0]) begin fails++; $display("FAIL full_ones: got %0d expected %0d", res_ones, ones); end
`endif
    drain(ok);
    checks++;
    if (!ok) begin fails++; $display("FAIL full_drain: handshake ok=%b expected 1", ok); end
  endtask

  task automatic test_wrap();
    int cyc; bit ok, order_ok; logic [31:0] exp_sig;
    logic [IN_W-1:0] exp_v[7] = '{10'd1020, 10'd1021, 10'd1022, 10'd1023, 10'd0, 10'd1, 10'd2};
    use_model = 1; exp_sig = SEED;
    for (int i = 0; i < 7; i++) exp_sig = misr_step(exp_sig, netlist(exp_v[i]));
    run_sweep(10'd1020, 10'd2, 100, cyc, ok);
    order_ok = (seen.size() == 7) && ok;
    for (int i = 0; i < 7 && i < seen.size(); i++) if (seen[i] !== exp_v[i]) order_ok = 0;
    checks++;
    if (!order_ok) begin fails++; $display("FAIL wrap_order: %0d vectors last=%0d expected 7 ending 2", seen.size(), seen[$]); end
    checks++;
    if (res_count !== 11'd7 || cyc != 22) begin
      fails++; $display("FAIL wrap_count: count=%0d cycles=%0d expected 7/22", res_count, cyc);
    end
    checks++;
    if (res_sig !== exp_sig) begin fails++; $display("FAIL wrap_sig: got %h expected %h", res_sig, exp_sig); end
    drain(ok);
    checks++;
    if (!ok) begin fails++; $display("FAIL wrap_drain: handshake ok=%b expected 1", ok); end
  endtask

  task automatic test_backpressure();
    int cyc; bit ok, stable; logic [31:0] exp_sig;
    use_model = 0; const_out = 30'h1234567; res_ready = 0;
    exp_sig = misr_step(SEED, 30'h1234567);
    run_sweep(10'd5, 10'd5, 20, cyc, ok);
    cmd_first = 10'd9; cmd_last = 10'd9; cmd_valid = 1'b1;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (res_valid !== 1 || res_sig !== exp_sig || res_count !== 11'd1 || cmd_ready !== 0 || dut_in !== 10'd5)
        stable = 1'b0;
      @(posedge clk); #1;
    end
    checks++;
    if (!stable) begin
      fails++; $display("FAIL bp_stable: rv=%b sig=%h cnt=%0d ready=%b expected 1/%h/1/0", res_valid, res_sig, res_count, cmd_ready, exp_sig);
    end
    res_ready = 1'b1; @(posedge clk); #1; res_ready = 1'b0;
    checks++;
    if (res_valid !== 0 || cmd_ready !== 1) begin
      fails++; $display("FAIL bp_release: rv=%b ready=%b expected 0/1", res_valid, cmd_ready);
    end
    @(posedge clk); #1; cmd_valid = 1'b0;
    checks++;
    if (busy !== 1 || dut_in !== 10'd9) begin
      fails++; $display("FAIL bp_accept: busy=%b dut_in=%0d expected 1/9", busy, dut_in);
    end
    drain(ok);
    checks++;
    if (!ok) begin fails++; $display("FAIL bp_drain: handshake ok=%b expected 1", ok); end
  endtask

  task automatic test_abort();
    bit rv_seen, ok;
    use_model = 0; const_out = 30'h1;
    cmd_first = 10'd100; cmd_last = 10'd200; cmd_valid = 1'b1;
    @(posedge clk); #1; cmd_valid = 1'b0;
    rv_seen = 0;
    repeat (14) begin @(posedge clk); #1; rv_seen |= (res_valid !== 1'b0); end
    checks++;
    if (dut_in !== 10'd104 || busy !== 1) begin
      fails++; $display("FAIL abort_pos: dut_in=%0d busy=%b expected 104/1", dut_in, busy);
    end
    abort = 1'b1; #1;
    checks++;
    if (cmd_ready !== 0) begin fails++; $display("FAIL abort_blocks: ready=%b expected 0", cmd_ready); end
    @(posedge clk); #1; abort = 1'b0; #1;
    rv_seen |= (res_valid !== 1'b0);
    checks++;
    if (busy !== 0 || cmd_ready !== 1 || rv_seen || dut_in !== 10'd104) begin
      fails++; $display("FAIL abort_idle: busy=%b ready=%b rv_seen=%b dut_in=%0d expected 0/1/0/104", busy, cmd_ready, rv_seen, dut_in);
    end
    cmd_first = 10'd7; cmd_last = 10'd7; cmd_valid = 1'b1;
    @(posedge clk); #1; cmd_valid = 1'b0;
    checks++;
    if (busy !== 1 || dut_in !== 10'd7) begin
      fails++; $display("FAIL abort_reaccept: busy=%b dut_in=%0d expected 1/7", busy, dut_in);
    end
    drain(ok);
    checks++;
    if (!ok) begin fails++; $display("FAIL abort_drain: handshake ok=%b expected 1", ok); end
  endtask

  task automatic test_rst_mid();
    int cyc, ones; bit ok; logic [31:0] exp_sig;
    use_model = 1;
    cmd_first = 10'd10; cmd_last = 10'd50; cmd_valid = 1'b1;
    @(posedge clk); #1; cmd_valid = 1'b0;
    repeat (4) @(posedge clk); #1;
    rst = 1'b1; #1;
    checks++;
    if (dut_in !== 0 || busy !== 0 || res_valid !== 0 || res_sig !== 0 || res_count !== 0) begin
      fails++; $display("FAIL rst_mid: dut_in=%0d busy=%b rv=%b sig=%h cnt=%0d expected all 0", dut_in, busy, res_valid, res_sig, res_count);
    end
`ifdef CCG_SWEEP_ONES_EN
    checks++;
    if (res_ones !== 0) begin fails++; $display("FAIL rst_ones: got %0d expected 0", res_ones); end
`endif
    #1; rst = 1'b0;
    exp_sig = SEED; ones = 0;
    for (int v = 0; v < 16; v++) begin
      exp_sig = misr_step(exp_sig, netlist(v[9:0]));
      if (netlist(v[9:0]) != 0) ones++;
    end
    @(posedge clk); #1;
    run_sweep(10'd0, 10'd15, 100, cyc, ok);
    checks++;
    if (res_count !== 11'd16 || res_sig !== exp_sig || !ok) begin
      fails++; $display("FAIL rst_resweep: cnt=%0d sig=%h hold_ok=%b expected 16/%h/1", res_count, res_sig, ok, exp_sig);
    end
`ifdef CCG_SWEEP_ONES_EN
    checks++;
    if (res_ones !== ones[10:0]) begin fails++; $display("FAIL rst_resweep_ones: got %0d expected %0d", res_ones, ones); end
`endif
    drain(ok);
    checks++;
    if (!ok) begin fails++; $display("FAIL rst_drain: handshake ok=%b expected 1", ok); end
  endtask

  initial begin
    checks = 0; fails = 0;
    test_reset();
    test_single();
    test_full_sweep();
    test_wrap();
    test_backpressure();
    test_abort();
    test_rst_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
